// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: arbitrates one operation at a time into a single ALU,
// returns the result over a valid/ready response port and keeps an [N Z V C] status register.
module alu (
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        err,
  output logic        wb
);
  logic [16:0] ext;
  logic        v;

  always_comb begin
    ext = 17'd0;
    v   = 1'b0;
    err = 1'b0;
    wb  = 1'b1;
    unique case (op)
      4'd0: begin
        ext = {1'b0, a} + {1'b0, b};
        v   = (a[15] == b[15]) && (ext[15] != a[15]);
      end
      4'd1: begin
        ext = {1'b0, a} - {1'b0, b};
        v   = (a[15] != b[15]) && (ext[15] != a[15]);
      end
      4'd2: ext = {1'b0, a} + 17'd1;
      4'd3: ext = {1'b0, a} - 17'd1;
      4'd4: ext = {1'b0, a & b};
      4'd5: ext = {1'b0, a | b};
      4'd6: ext = {1'b0, a ^ b};
      4'd7: ext = {1'b0, ~a};
      4'd8: begin
        ext = {1'b0, a} - {1'b0, b};
        wb  = 1'b0;
      end
      default: begin
        err = 1'b1;
        wb  = 1'b0;
      end
    endcase
  end

  // Bit 16 of the extended result is carry for adds and borrow for subtracts.
  assign result = err ? 16'h0000 : ext[15:0];
  assign flags  = err ? 4'b0100 : {ext[15], ext[15:0] == 16'h0000, v, ext[16]};
endmodule

module alu_sched #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_wb,
  output logic        rsp_err,
  output logic [3:0]  flags_q,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        id;
  } cap_t;

  state_t      state_q, state_d;
  cap_t        cap_q;
  logic        last_grant;
  logic        gnt_id;
  logic        hs;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_err, alu_wb;

  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid)
      gnt_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    else if (req1_valid)
      gnt_id = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
  assign req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
  assign hs         = req0_ready || req1_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ALU sees only the captured operation, never the live requester ports.
  alu u_alu (
    .op     (cap_q.op),
    .a      (cap_q.a),
    .b      (cap_q.b),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err),
    .wb     (alu_wb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q      <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_flags  <= 4'h0;
      rsp_wb     <= 1'b0;
      rsp_err    <= 1'b0;
      flags_q    <= 4'h0;
    end else begin
      if (hs) begin
        cap_q      <= gnt_id ? cap_t'{req1_op, req1_a, req1_b, 1'b1}
                             : cap_t'{req0_op, req0_a, req0_b, 1'b0};
        last_grant <= gnt_id;
      end
      if (state_q == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= cap_q.id;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_wb     <= alu_wb;
        rsp_err    <= alu_err;
        if (!alu_err) flags_q <= alu_flags;
      end
      if (state_q == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: round-robin (u_dut) and fixed-priority (u_dut_fx) copies share stimulus.
module tb_alu_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_op = 4'h0, req1_op = 4'h0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic        rsp_ready = 1'b1;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_wb, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags, flags_q;
  logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_wb, f_rsp_err, f_busy;
  logic [15:0] f_rsp_result;
  logic [3:0]  f_rsp_flags, f_flags_q;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sched #(.PRIO_FIXED(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_wb(rsp_wb), .rsp_err(rsp_err), .flags_q(flags_q), .busy(busy)
  );

  alu_sched #(.PRIO_FIXED(1)) u_dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
    .rsp_flags(f_rsp_flags), .rsp_wb(f_rsp_wb), .rsp_err(f_rsp_err), .flags_q(f_flags_q), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, check it is granted combinationally, and return just past the handshake edge.
  task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk("ready_granted", id ? req1_ready : req0_ready, 1'b1);
    chk("ready_other",   id ? req0_ready : req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [3:0]  fl;
    logic        wb;
  } vec_t;

  vec_t vt[7];
  int   n;
  logic [3:0] exp_id0 [4];
  logic [3:0] exp_id1 [4];

  initial begin
    vt[0] = '{4'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1};
    vt[1] = '{4'd5, 16'h8000, 16'h0001, 16'h8001, 4'b1000, 1'b1};
    vt[2] = '{4'd6, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1'b1};
    vt[3] = '{4'd7, 16'h00FF, 16'h1234, 16'hFF00, 4'b1000, 1'b1};
    vt[4] = '{4'd2, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101, 1'b1};
    vt[5] = '{4'd3, 16'h0000, 16'h0000, 16'hFFFF, 4'b1001, 1'b1};
    vt[6] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 1'b1};
    exp_id0 = '{4'd0, 4'd1, 4'd0, 4'd1};
    exp_id1 = '{4'd0, 4'd0, 4'd0, 4'd0};

    // Reset state
    #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags_q", flags_q, 4'h0);
    chk("rst_result", rsp_result, 16'h0);
    #11 rst_n = 1'b1;
    step();

    // ADD overflow into sign bit
    rsp_ready = 1'b1;
    issue(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    chk("exec_busy", busy, 1'b1);
    chk("exec_no_rsp", rsp_valid, 1'b0);
    wait_rsp(n);
    chk("add_latency", n, 1);
    chk("add_result", rsp_result, 16'h8000);
    chk("add_flags", rsp_flags, 4'b1010);
    chk("add_wb", rsp_wb, 1'b1);
    chk("add_id", rsp_id, 1'b0);
    chk("add_err", rsp_err, 1'b0);
    chk("add_flags_q", flags_q, 4'b1010);
    step();
    chk("idle_after_rsp", busy, 1'b0);
    chk("rsp_dropped", rsp_valid, 1'b0);

    // CMP equal from requester 1
    issue(1'b1, 4'd8, 16'h0005, 16'h0005);
    wait_rsp(n);
    chk("cmp_result", rsp_result, 16'h0000);
    chk("cmp_flags", rsp_flags, 4'b0100);
    chk("cmp_wb", rsp_wb, 1'b0);
    chk("cmp_id", rsp_id, 1'b1);
    chk("cmp_flags_q", flags_q, 4'b0100);
    step();

    // Remaining opcodes and boundary carries
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, vt[i].op, vt[i].a, vt[i].b);
      wait_rsp(n);
      chk($sformatf("vec%0d_result", i), rsp_result, vt[i].res);
      chk($sformatf("vec%0d_flags", i), rsp_flags, vt[i].fl);
      chk($sformatf("vec%0d_flags_q", i), flags_q, vt[i].fl);
      chk($sformatf("vec%0d_wb", i), rsp_wb, vt[i].wb);
      step();
    end

    // Invalid opcode leaves flags_q alone (prime it to 0001 with FFFF+2)
    issue(1'b0, 4'd0, 16'hFFFF, 16'h0002);
    wait_rsp(n);
    chk("prime_flags_q", flags_q, 4'b0001);
    step();
    issue(1'b0, 4'hC, 16'h1234, 16'h5678);
    wait_rsp(n);
    chk("inv_err", rsp_err, 1'b1);
    chk("inv_result", rsp_result, 16'h0000);
    chk("inv_flags", rsp_flags, 4'b0100);
    chk("inv_wb", rsp_wb, 1'b0);
    chk("inv_flags_q", flags_q, 4'b0001);
    step();

    // SUB borrow with consumer stalled; nobody may be accepted meanwhile
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 16'h0000, 16'h0001);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_result", rsp_result, 16'hFFFF);
      chk("stall_flags", rsp_flags, 4'b1001);
      chk("stall_ready0", req0_ready, 1'b0);
      chk("stall_ready1", req1_ready, 1'b0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("stall_release", rsp_valid, 1'b0);

    // Reset in RESP drops the operation
    rsp_ready = 1'b0;
    issue(1'b1, 4'd0, 16'h0001, 16'h0001);
    wait_rsp(n);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", rsp_valid, 1'b0);
    chk("rst_resp_flags_q", flags_q, 4'h0);
    chk("rst_resp_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_rsp_after_rst", rsp_valid, 1'b0);
    end

    // Continuous tie: round-robin vs fixed priority, 3 cycles per op
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h0010; req0_b = 16'h0;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'h0010; req1_b = 16'h0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("tie%0d_cycles", k), n, 2);
      chk($sformatf("tie%0d_fx_valid", k), f_rsp_valid, 1'b1);
      chk($sformatf("tie%0d_rr_id", k), rsp_id, exp_id0[k][0]);
      chk($sformatf("tie%0d_fx_id", k), f_rsp_id, exp_id1[k][0]);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: PRIO_FIXED, 0, 0 = round-robin arbitration; 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  requester N is accepted this cycle.
REQ-006 reqN_op  input  4  opcode: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 CMP; 9-15 invalid.
REQ-007 reqN_a, reqN_b  input  16  operands s1, s2.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  consumer accepts response.
REQ-010 rsp_id  output  1  requester that issued the operation.
REQ-011 rsp_result  output  16  ALU result.
REQ-012 rsp_flags  output  4  flags of this operation, [N Z V C].
REQ-013 rsp_wb  output  1  result is to be written back (0 for CMP and invalid ops).
REQ-014 rsp_err  output  1  opcode was invalid.
REQ-015 flags_q  output  4  architectural status register [N Z V C].
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 Block shall instantiate one alu; its opcode/operand inputs shall be driven only from internal capture registers, never directly from requester ports.
REQ-018 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on any handshake, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1, else hold RESP.
REQ-019 reqN_ready shall be asserted only in IDLE, combinationally, for exactly the granted requester, and only when that reqN_valid=1.
REQ-020 Grant with one valid requester: that requester.
REQ-021 Grant with both valid, PRIO_FIXED=0: requester not granted last; PRIO_FIXED=1: requester 0.
REQ-022 last-grant register shall update only on a completed handshake; reset value 1 so requester 0 wins the first tie.
REQ-023 On handshake, op, a, b and requester id shall be captured; requesters shall hold valid and operands stable until ready.
REQ-024 In EXEC, ALU outputs shall be registered into rsp_result/rsp_flags; rsp_valid shall rise in the following cycle (handshake at cycle T -> rsp_valid at T+2).
REQ-025 rsp_* outputs shall remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Arithmetic shall be 16-bit wrap-around; C from 17-bit extended result (borrow for SUB/DEC/CMP); V only for ADD/SUB; logic ops C=0, V=0.
REQ-027 flags_q shall load the ALU flags on the EXEC->RESP transition for opcodes 0-8; invalid opcodes shall leave flags_q unchanged.
REQ-028 rsp_wb = 1 for opcodes 0-7, 0 for CMP and invalid; rsp_err = 1 only for opcodes 9-15, with rsp_result=0 and rsp_flags=4'b0100.
REQ-029 No new request shall be accepted in EXEC or RESP; throughput max one operation per 3 cycles; rsp_ready held high gives exactly 3 cycles per op.
REQ-030 rsp_ready asserted while rsp_valid=0 shall have no effect.

Reset
REQ-031 rst_n low shall immediately force IDLE, clear capture registers, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_wb, rsp_err, flags_q to 0, busy to 0, last-grant to 1.
REQ-032 Reset during EXEC or RESP shall drop the in-flight operation with no response and no flags_q update.
REQ-033 After rst_n deasserts, first handshake possible in the first IDLE cycle.

Verification
REQ-034 req0 ADD a=16'h7FFF b=16'h0001, rsp_ready=1 -> rsp_valid at T+2, result 16'h8000, flags 4'b1010, rsp_wb=1, rsp_id=0, flags_q=4'b1010.
REQ-035 req1 CMP a=16'h0005 b=16'h0005 -> result 16'h0000, flags 4'b0100, rsp_wb=0, flags_q=4'b0100.
REQ-036 Both valid continuously, PRIO_FIXED=0, four ops -> rsp_id sequence 0,1,0,1; with PRIO_FIXED=1 -> 0,0,0,0.
REQ-037 req0 op=4'hC after flags_q=4'b0001 -> rsp_err=1, result 0, flags 4'b0100, flags_q stays 4'b0001.
REQ-038 SUB a=16'h0000 b=16'h0001 with rsp_ready=0 for 5 cycles -> rsp_valid held, result 16'hFFFF, flags 4'b1001 stable, both reqN_ready=0 throughout.
REQ-039 rst_n pulsed low during RESP -> rsp_valid, flags_q, busy 0 at once; no response after release; next tie grants requester 0.
